// File: rtl/rc5_pkg.sv
// Shared RC5 defaults and control-state encoding for the iterative RC5 core.
package rc5_pkg;

    localparam int RC5_W_DEFAULT = 32;
    localparam int RC5_R_DEFAULT = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_S  = 3'd1,
        PRE_A   = 3'd2,
        PRE_B   = 3'd3,
        ROUND_A = 3'd4,
        ROUND_B = 3'd5,
        DONE    = 3'd6
    } rc5_state_e;

endpackage

// File: rtl/rc5_rotate.sv
// Combinational variable rotate of one W-bit word: iDir=0 rotates left, iDir=1 rotates right.
module rc5_rotate import rc5_pkg::*; #(
    parameter  int W  = RC5_W_DEFAULT,
    localparam int RW = $clog2(W)
) (
    input  logic [W-1:0]  iData,
    input  logic [RW-1:0] iRotate,
    input  logic          iDir,
    output logic [W-1:0]  oData
);

    logic [2*W-1:0] dbl, shl, shr;

    // Doubling the word turns the rotate into a plain shift of a 2W vector.
    assign dbl   = {iData, iData};
    assign shl   = dbl << iRotate;
    assign shr   = dbl >> iRotate;
    assign oData = iDir ? shr[W-1:0] : shl[2*W-1:W];

endmodule

// File: rtl/rc5_encrypt.sv
// Iterative RC5-W/R block core: one half-round per cycle, S-table read externally with one-cycle latency.
// Define RC5_DECRYPT_EN to add the iDecrypt input and the inverse data path.
module rc5_encrypt import rc5_pkg::*; #(
    parameter  int W        = RC5_W_DEFAULT,
    parameter  int R        = RC5_R_DEFAULT,
    localparam int T        = 2*R + 2,
    localparam int T_LENGTH = $clog2(T),
    localparam int ROTVALUE = $clog2(W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iStart,
`ifdef RC5_DECRYPT_EN
    input  logic                iDecrypt,
`endif
    input  logic [W-1:0]        iPlainA,
    input  logic [W-1:0]        iPlainB,
    output logic [T_LENGTH-1:0] oS_address,
    input  logic [W-1:0]        iS_sub_i,
    output logic [W-1:0]        oCipherA,
    output logic [W-1:0]        oCipherB,
    output logic                oBusy,
    output logic                oDone
);

    localparam int RND_W = $clog2(R + 1);

    rc5_state_e          state_q, state_d;
    logic [W-1:0]        a_q, a_d, b_q, b_d;
    logic [W-1:0]        ca_q, ca_d, cb_q, cb_d;
    logic [RND_W-1:0]    rnd_q, rnd_d;
    logic [T_LENGTH-1:0] addr_q, addr_d, addr_step;
    logic                done_q, done_d;
    logic                dec_q, dec_d;
    logic                dec_start;

    logic [W-1:0]          rot_din, rot_dout;
    logic [ROTVALUE-1:0]   rot_amt;
    logic [W-1:0]          a_sub, b_sub;

`ifdef RC5_DECRYPT_EN
    assign dec_start = iDecrypt;
`else
    assign dec_start = 1'b0;
`endif

    assign a_sub = a_q - iS_sub_i;
    assign b_sub = b_q - iS_sub_i;

    // Address walks up for encryption, down for decryption, and parks at the table edge.
    always_comb begin
        addr_step = addr_q;
        if (dec_q) begin
            if (addr_q != '0)
                addr_step = addr_q - 1'b1;
        end else begin
            if (addr_q != T_LENGTH'(T - 1))
                addr_step = addr_q + 1'b1;
        end
    end

    // One rotator serves both half-rounds; the A half rotates by B and vice versa.
    always_comb begin
        if (state_q == ROUND_A) begin
            rot_din = dec_q ? a_sub : (a_q ^ b_q);
            rot_amt = b_q[ROTVALUE-1:0];
        end else begin
            rot_din = dec_q ? b_sub : (b_q ^ a_q);
            rot_amt = a_q[ROTVALUE-1:0];
        end
    end

    rc5_rotate #(.W(W)) u_rot (
        .iData   (rot_din),
        .iRotate (rot_amt),
        .iDir    (dec_q),
        .oData   (rot_dout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rnd_d   = rnd_q;
        addr_d  = addr_q;
        ca_d    = ca_q;
        cb_d    = cb_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    a_d     = iPlainA;
                    b_d     = iPlainB;
                    dec_d   = dec_start;
                    addr_d  = dec_start ? T_LENGTH'(T - 1) : '0;
                    rnd_d   = dec_start ? RND_W'(R) : RND_W'(1);
                    state_d = WAIT_S;
                end
            end
            WAIT_S: begin
                addr_d  = addr_step;
                state_d = dec_q ? ROUND_B : PRE_A;
            end
            PRE_A: begin
                addr_d = addr_step;
                if (dec_q) begin
                    // Last step of decryption: publish the recovered block.
                    a_d     = a_sub;
                    ca_d    = a_sub;
                    cb_d    = b_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    a_d     = a_q + iS_sub_i;
                    state_d = PRE_B;
                end
            end
            PRE_B: begin
                addr_d = addr_step;
                if (dec_q) begin
                    b_d     = b_sub;
                    state_d = PRE_A;
                end else begin
                    b_d     = b_q + iS_sub_i;
                    state_d = ROUND_A;
                end
            end
            ROUND_A: begin
                addr_d = addr_step;
                if (dec_q) begin
                    a_d = rot_dout ^ b_q;
                    if (rnd_q > RND_W'(1)) begin
                        rnd_d   = rnd_q - 1'b1;
                        state_d = ROUND_B;
                    end else begin
                        state_d = PRE_B;
                    end
                end else begin
                    a_d     = rot_dout + iS_sub_i;
                    state_d = ROUND_B;
                end
            end
            ROUND_B: begin
                addr_d = addr_step;
                if (dec_q) begin
                    b_d     = rot_dout ^ a_q;
                    state_d = ROUND_A;
                end else begin
                    b_d = rot_dout + iS_sub_i;
                    if (rnd_q < RND_W'(R)) begin
                        rnd_d   = rnd_q + 1'b1;
                        state_d = ROUND_A;
                    end else begin
                        ca_d    = a_q;
                        cb_d    = rot_dout + iS_sub_i;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rnd_q   <= '0;
            addr_q  <= '0;
            ca_q    <= '0;
            cb_q    <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rnd_q   <= rnd_d;
            addr_q  <= addr_d;
            ca_q    <= ca_d;
            cb_q    <= cb_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    assign oS_address = addr_q;
    assign oCipherA   = ca_q;
    assign oCipherB   = cb_q;
    assign oDone      = done_q;
    assign oBusy      = (state_q != IDLE);

endmodule
